// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared line layout, state encoding and write-back word packing for the L1 cache.
package cache_pkg;

  localparam int NUM_SETS = 4;
  localparam int SET_W    = 2;
  localparam int TAG_W    = 8;
  localparam int DATA_W   = 3;

  // Packed line view {V, D, LRU, tag, data}; LRU is reserved in a direct-mapped cache.
  localparam int V       = 13;
  localparam int D       = 12;
  localparam int LRU     = 11;
  localparam int TAG_MSB = 10;
  localparam int TAG_LSB = 3;

  localparam int WB_W = 1 + SET_W + TAG_W + DATA_W;

  typedef enum logic [1:0] {IDLE, WBACK, MISS, FILL} state_t;

  function automatic logic [WB_W-1:0] wback_word(input logic [SET_W-1:0] set,
                                                 input logic [TAG_W-1:0] tag,
                                                 input logic [DATA_W-1:0] data);
    return {1'b1, set, tag, data};
  endfunction

endpackage

// File: rtl/cachel1_array.sv
// rtl/cachel1_array.sv - four-line tag/data storage, combinational read, per-field synchronous write.
module cachel1_array
  import cache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [SET_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic [SET_W-1:0]  wr_idx,
  input  logic              wr_valid_en,
  input  logic              wr_dirty_en,
  input  logic              wr_tag_en,
  input  logic              wr_data_en,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic              valid_q [NUM_SETS];
  logic              dirty_q [NUM_SETS];
  logic [TAG_W-1:0]  tag_q   [NUM_SETS];
  logic [DATA_W-1:0] data_q  [NUM_SETS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      if (wr_valid_en) valid_q[wr_idx] <= wr_valid;
      if (wr_dirty_en) dirty_q[wr_idx] <= wr_dirty;
      if (wr_tag_en)   tag_q[wr_idx]   <= wr_tag;
      if (wr_data_en)  data_q[wr_idx]  <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/cachel1.sv
// rtl/cachel1.sv - direct-mapped write-back/write-allocate L1 controller in front of cachel2.
// Defining CACHEL1_STATS_EN adds saturating hit_count/miss_count outputs.
module cachel1
  import cache_pkg::*;
#(
  parameter int MISS_TIMEOUT = 32,
  parameter int CNT_W        = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_add,
  input  logic [7:0]  cpu_tag,
  input  logic [2:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_hit,
  output logic [2:0]  cpu_rdata,
  output logic        missout,
  output logic [10:0] dataout,
  output logic [2:0]  addout,
  output logic        wbackout,
  output logic [13:0] wbackdataout,
  input  logic [10:0] in,
  output logic        timeout
`ifdef CACHEL1_STATS_EN
  ,
  output logic [7:0]  hit_count,
  output logic [7:0]  miss_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISS_TIMEOUT - 1);

  state_t            state;
  logic [2:0]        lat_add;
  logic [TAG_W-1:0]  lat_tag;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  cnt;

  logic [SET_W-1:0]  rd_idx;
  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              wr_valid_en, wr_dirty_en, wr_tag_en, wr_data_en;
  logic              wr_valid, wr_dirty;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;
  logic              hit, fill_ok;
  logic [DATA_W-1:0] fill_data;

  // Only IDLE looks at the live CPU address; every later state works on the latched miss.
  assign rd_idx    = (state == IDLE) ? cpu_add[SET_W-1:0] : lat_add[SET_W-1:0];
  assign hit       = rd_valid && (rd_tag == cpu_tag);
  assign fill_ok   = (in != '0) && (in[TAG_MSB:TAG_LSB] == lat_tag);
  assign fill_data = lat_we ? lat_wdata : in[DATA_W-1:0];

  cachel1_array u_array (
    .clock       (clock),
    .reset       (reset),
    .rd_idx      (rd_idx),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .wr_idx      (rd_idx),
    .wr_valid_en (wr_valid_en),
    .wr_dirty_en (wr_dirty_en),
    .wr_tag_en   (wr_tag_en),
    .wr_data_en  (wr_data_en),
    .wr_valid    (wr_valid),
    .wr_dirty    (wr_dirty),
    .wr_tag      (wr_tag),
    .wr_data     (wr_data)
  );

  always_comb begin
    wr_valid_en = 1'b0;
    wr_dirty_en = 1'b0;
    wr_tag_en   = 1'b0;
    wr_data_en  = 1'b0;
    wr_valid    = 1'b0;
    wr_dirty    = 1'b0;
    wr_tag      = lat_tag;
    wr_data     = cpu_wdata;
    case (state)
      IDLE: begin
        if (cpu_req && hit && cpu_we) begin
          wr_data_en  = 1'b1;
          wr_dirty_en = 1'b1;
          wr_dirty    = 1'b1;
        end
      end
      WBACK: wr_dirty_en = 1'b1;
      MISS: begin
        // A write miss merges its data into the refill, leaving the line dirty.
        if (fill_ok) begin
          wr_valid_en = 1'b1;
          wr_dirty_en = 1'b1;
          wr_tag_en   = 1'b1;
          wr_data_en  = 1'b1;
          wr_valid    = 1'b1;
          wr_dirty    = lat_we;
          wr_data     = fill_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cpu_ready    <= 1'b0;
      cpu_hit      <= 1'b0;
      cpu_rdata    <= '0;
      missout      <= 1'b0;
      dataout      <= '0;
      addout       <= '0;
      wbackout     <= 1'b0;
      wbackdataout <= '0;
      timeout      <= 1'b0;
      lat_add      <= '0;
      lat_tag      <= '0;
      lat_we       <= 1'b0;
      lat_wdata    <= '0;
      cnt          <= '0;
    end else begin
      cpu_ready    <= 1'b0;
      cpu_hit      <= 1'b0;
      cpu_rdata    <= '0;
      wbackout     <= 1'b0;
      wbackdataout <= '0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (hit) begin
              cpu_ready <= 1'b1;
              cpu_hit   <= 1'b1;
              cpu_rdata <= cpu_we ? cpu_wdata : rd_data;
            end else begin
              lat_add   <= cpu_add;
              lat_tag   <= cpu_tag;
              lat_we    <= cpu_we;
              lat_wdata <= cpu_wdata;
              cnt       <= '0;
              if (rd_valid && rd_dirty) begin
                state        <= WBACK;
                wbackout     <= 1'b1;
                wbackdataout <= wback_word(cpu_add[SET_W-1:0], rd_tag, rd_data);
              end else begin
                state   <= MISS;
                missout <= 1'b1;
                dataout <= {cpu_tag, {DATA_W{1'b0}}};
                addout  <= cpu_add;
              end
            end
          end
        end
        WBACK: begin
          state   <= MISS;
          missout <= 1'b1;
          dataout <= {lat_tag, {DATA_W{1'b0}}};
          addout  <= lat_add;
        end
        MISS: begin
          if (fill_ok) begin
            state     <= FILL;
            missout   <= 1'b0;
            dataout   <= '0;
            addout    <= '0;
            cpu_ready <= 1'b1;
            cpu_rdata <= fill_data;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            missout   <= 1'b0;
            dataout   <= '0;
            addout    <= '0;
            timeout   <= 1'b1;
            cpu_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FILL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHEL1_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE && cpu_req) begin
      if (hit) begin
        if (hit_count != 8'hFF) hit_count <= hit_count + 1'b1;
      end else begin
        if (miss_count != 8'hFF) miss_count <= miss_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cachel1.sv
// tb/tb_cachel1.sv - scoreboard bench for cachel1 with a behavioural L1 model and an L2 responder.
module tb_cachel1;

  localparam int MISS_TIMEOUT = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [2:0]  cpu_add = '0;
  logic [7:0]  cpu_tag = '0;
  logic [2:0]  cpu_wdata = '0;
  logic [10:0] in = '0;
  logic        cpu_ready, cpu_hit, missout, wbackout, timeout;
  logic [2:0]  cpu_rdata, addout;
  logic [10:0] dataout;
  logic [13:0] wbackdataout;
`ifdef CACHEL1_STATS_EN
  logic [7:0]  hit_count, miss_count;
`endif

  cachel1 #(.MISS_TIMEOUT(MISS_TIMEOUT), .CNT_W(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_add      (cpu_add),
    .cpu_tag      (cpu_tag),
    .cpu_wdata    (cpu_wdata),
    .cpu_ready    (cpu_ready),
    .cpu_hit      (cpu_hit),
    .cpu_rdata    (cpu_rdata),
    .missout      (missout),
    .dataout      (dataout),
    .addout       (addout),
    .wbackout     (wbackout),
    .wbackdataout (wbackdataout),
    .in           (in),
    .timeout      (timeout)
`ifdef CACHEL1_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       hit;
    logic [2:0] rdata;
    logic       to;
  } resp_t;

  int checks = 0;
  int errors = 0;

  resp_t       exp_resp[$];
  logic [13:0] exp_wb[$];
  logic [10:0] exp_miss[$];

  // Reference model: one entry per set plus the bench's view of L2 contents.
  logic       m_valid[4];
  logic       m_dirty[4];
  logic [7:0] m_tag[4];
  logic [2:0] m_data[4];
  logic       m_to;
  int         m_hits, m_misses;
  logic [2:0] l2mem [bit [9:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
    m_to     = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Monitor: every DUT output event is matched against the head of a queue.
  logic prev_miss = 1'b0;
  always @(negedge clock) begin
    resp_t r;
    if (cpu_ready) begin
      if (exp_resp.size() == 0) fail_now("unexpected_cpu_ready");
      else begin
        r = exp_resp.pop_front();
        check("cpu_hit", {31'b0, cpu_hit}, {31'b0, r.hit});
        check("cpu_rdata", {29'b0, cpu_rdata}, {29'b0, r.rdata});
        check("timeout_flag", {31'b0, timeout}, {31'b0, r.to});
      end
    end
    if (wbackout) begin
      if (exp_wb.size() == 0) fail_now("unexpected_wbackout");
      else check("wbackdataout", {18'b0, wbackdataout}, {18'b0, exp_wb.pop_front()});
      check("missout_in_wback", {31'b0, missout}, 32'd0);
    end
    if (missout) begin
      if (exp_miss.size() == 0) fail_now("unexpected_missout");
      else begin
        check("dataout", {21'b0, dataout}, {21'b0, exp_miss[0][7:0], 3'b000});
        check("addout", {29'b0, addout}, {29'b0, exp_miss[0][10:8]});
      end
    end
    if (prev_miss && !missout && exp_miss.size() > 0) void'(exp_miss.pop_front());
    prev_miss = missout;
  end

  task automatic wait_ready(input string name);
    for (int k = 0; k < 8 && !cpu_ready; k++) @(negedge clock);
    if (!cpu_ready) fail_now(name);
  endtask

  // mode: 0 fill after random latency, 1 wrong-tag noise first, 2 never fill, 3 reset mid-miss
  task automatic do_req(input logic we, input logic [2:0] add, input logic [7:0] tag,
                        input logic [2:0] wdata, input int mode, input logic [10:0] noise);
    logic [1:0]  s;
    logic        is_hit;
    logic [2:0]  fd, rd;
    logic [10:0] fill_in;
    int          cnt;
    s = add[1:0];
    is_hit = m_valid[s] && (m_tag[s] == tag);
    fill_in = '0;
    if (is_hit) begin
      rd = we ? wdata : m_data[s];
      if (we) begin
        m_data[s]  = wdata;
        m_dirty[s] = 1'b1;
      end
      if (m_hits < 255) m_hits++;
      exp_resp.push_back('{hit: 1'b1, rdata: rd, to: m_to});
    end else begin
      if (m_misses < 255) m_misses++;
      if (m_valid[s] && m_dirty[s]) begin
        exp_wb.push_back({1'b1, s, m_tag[s], m_data[s]});
        l2mem[{s, m_tag[s]}] = m_data[s];
        m_dirty[s] = 1'b0;
      end
      exp_miss.push_back({add, tag});
      if (!l2mem.exists({s, tag})) l2mem[{s, tag}] = 3'($urandom_range(0, 7));
      fd = l2mem[{s, tag}];
      fill_in = {tag, fd};
      if (mode == 2) begin
        m_to = 1'b1;
        exp_resp.push_back('{hit: 1'b0, rdata: 3'b000, to: 1'b1});
      end else if (mode != 3) begin
        m_valid[s] = 1'b1;
        m_tag[s]   = tag;
        m_dirty[s] = we;
        m_data[s]  = we ? wdata : fd;
        exp_resp.push_back('{hit: 1'b0, rdata: (we ? wdata : fd), to: m_to});
      end
    end

    @(negedge clock);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_add   = add;
    cpu_tag   = tag;
    cpu_wdata = wdata;
    @(negedge clock);
    cpu_req = 1'b0;

    if (is_hit) wait_ready("hit_response_timeout");
    else begin
      for (int k = 0; k < 4 && !missout; k++) @(negedge clock);
      if (!missout) fail_now("missout_never_rose");
      else if (mode == 2) begin
        cnt = 0;
        for (int k = 0; k < 100 && !cpu_ready; k++) begin
          if (missout) cnt++;
          @(negedge clock);
        end
        if (!cpu_ready) fail_now("timeout_response_missing");
        check("miss_cycles_before_timeout", cnt, MISS_TIMEOUT);
        check("missout_after_timeout", {31'b0, missout}, 32'd0);
      end else if (mode == 3) begin
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("missout_after_reset", {31'b0, missout}, 32'd0);
        check("ready_after_reset", {31'b0, cpu_ready}, 32'd0);
        check("timeout_after_reset", {31'b0, timeout}, 32'd0);
        reset = 1'b0;
        model_reset();
      end else begin
        if (mode == 1) begin
          for (int k = 0; k < 3; k++) begin
            in = noise;
            @(negedge clock);
            check("missout_held_on_noise", {31'b0, missout}, 32'd1);
            check("no_fill_on_noise", {31'b0, cpu_ready}, 32'd0);
          end
        end else begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        in = fill_in;
        wait_ready("fill_response_timeout");
        in = '0;
      end
    end
    @(posedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] pool [4];
    pool[0] = 8'h11; pool[1] = 8'h22; pool[2] = 8'h33; pool[3] = 8'h44;
    model_reset();

    repeat (2) @(negedge clock);
    check("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    check("rst_cpu_hit", {31'b0, cpu_hit}, 32'd0);
    check("rst_cpu_rdata", {29'b0, cpu_rdata}, 32'd0);
    check("rst_missout", {31'b0, missout}, 32'd0);
    check("rst_dataout", {21'b0, dataout}, 32'd0);
    check("rst_addout", {29'b0, addout}, 32'd0);
    check("rst_wbackout", {31'b0, wbackout}, 32'd0);
    check("rst_wbackdataout", {18'b0, wbackdataout}, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    reset = 1'b0;

    // Read miss then re-read hit on set 1, tag 0x64, L2 returns 7.
    l2mem[{2'b01, 8'h64}] = 3'h7;
    do_req(1'b0, 3'b001, 8'h64, 3'b000, 0, '0);
    do_req(1'b0, 3'b001, 8'h64, 3'b000, 0, '0);
    // Write hit dirties the line, then a conflicting read forces the write-back.
    do_req(1'b1, 3'b001, 8'h64, 3'b010, 0, '0);
    l2mem[{2'b01, 8'h80}] = 3'h3;
    do_req(1'b0, 3'b001, 8'h80, 3'b000, 0, '0);
    check("l2_wback_word", {18'b0, 1'b1, 2'b01, m_tag[1] ^ 8'h80 ^ 8'h64, l2mem[{2'b01, 8'h64}]},
          {18'b0, 14'b1_01_01100100_010});
`ifdef CACHEL1_STATS_EN
    check("hit_count", {24'b0, hit_count}, m_hits);
    check("miss_count", {24'b0, miss_count}, m_misses);
`endif

    do_req(1'b0, 3'b110, 8'h5A, 3'b000, 1, 11'h3FF);
    do_req(1'b1, 3'b011, 8'h99, 3'b101, 2, '0);
    repeat (3) @(negedge clock);
    check("timeout_sticky", {31'b0, timeout}, 32'd1);
    do_req(1'b0, 3'b001, 8'h80, 3'b000, 0, '0);

    do_req(1'b0, 3'b100, 8'h42, 3'b000, 3, '0);
    do_req(1'b0, 3'b100, 8'h42, 3'b000, 0, '0);
    do_req(1'b0, 3'b001, 8'h80, 3'b000, 0, '0);

    for (int i = 0; i < 200; i++) begin
      logic [7:0] t;
      int         md;
      t  = pool[$urandom_range(0, 3)];
      md = ($urandom_range(0, 19) == 0) ? 2 : int'($urandom_range(0, 1));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), t, 3'($urandom_range(0, 7)),
             md, {~t, 3'($urandom_range(0, 7))});
    end
`ifdef CACHEL1_STATS_EN
    check("hit_count_final", {24'b0, hit_count}, m_hits);
    check("miss_count_final", {24'b0, miss_count}, m_misses);
`endif

    repeat (4) @(negedge clock);
    check("resp_queue_drained", exp_resp.size(), 0);
    check("wb_queue_drained", exp_wb.size(), 0);
    check("miss_queue_drained", exp_miss.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
